// File: rtl/dice_roller.sv
// -----------------------------------------------------------------------------
// dice_roller
//
// Dice datapath and button front end for the dice game controller.
//   * Conditions the raw roll pushbutton into a clean debounced level (rb).
//   * Advances two cascaded 1..6 dice counters while the controller holds roll.
//   * On the falling edge of roll, registers die1+die2 onto sum and pulses
//     sum_valid for one cycle.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive cycles the synchronized button must differ
//                    from rb before rb follows it (1..255).
//
// Ports:
//   clk        in   1  single clock, rising-edge active
//   reset      in   1  asynchronous, active-high reset
//   btn        in   1  raw pushbutton, asynchronous to clk, may bounce
//   roll       in   1  roll command; dice advance while high
//   rb         out  1  debounced button level
//   die1       out  3  first die value, 1..6
//   die2       out  3  second die value, 1..6
//   sum        out  4  registered die1+die2 (2..12), 0 only after reset
//   sum_valid  out  1  one-cycle pulse when sum is updated
// -----------------------------------------------------------------------------
module dice_roller #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn,
   input  logic       roll,
   output logic       rb,
   output logic [2:0] die1,
   output logic [2:0] die2,
   output logic [3:0] sum,
   output logic       sum_valid
);

   // Counter is wide enough for the full legal parameter range (1..255).
   localparam int         CNT_W    = 8;
   localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

   // Next value of a single die. Anything that is not 1..5 (i.e. 6, or the
   // illegal codes 0 and 7) wraps to 1, so a corrupted die recovers on the
   // next advance.
   function automatic logic [2:0] die_next(input logic [2:0] d);
      if ((d >= 3'd6) || (d == 3'd0)) begin
         return 3'd1;
      end
      return d + 3'd1;
   endfunction

   // Dice total widened to 4 bits; 6+6=12 fits, so no saturation is needed.
   function automatic logic [3:0] dice_total(input logic [2:0] a,
                                             input logic [2:0] b);
      return {1'b0, a} + {1'b0, b};
   endfunction

   logic             r_btn_p0;
   logic             r_btn_p1;
   logic [CNT_W-1:0] r_db_cnt;
   logic             r_rb;
   logic [2:0]       r_die1;
   logic [2:0]       r_die2;
   logic             r_roll_d;
   logic [3:0]       r_sum;
   logic             r_sum_valid;

   logic             w_btn_s;
   logic [2:0]       w_die1_nxt;
   logic [2:0]       w_die2_nxt;
   logic             w_die1_wrap;
   logic             w_roll_fall;
   logic [3:0]       w_sum_nxt;

   // ---- stage p0/p1: two-flop synchronizer for the asynchronous button ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_btn_p0 <= 1'b0;
         r_btn_p1 <= 1'b0;
      end else begin
         r_btn_p0 <= btn;
         r_btn_p1 <= r_btn_p0;
      end
   end

   assign w_btn_s = r_btn_p1;

   // ---- debounce: rb follows btn_s only after a run of disagreeing cycles ----
   // Any single agreeing cycle clears the run, so bounces shorter than
   // DEBOUNCE_CYCLES never reach rb.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_db_cnt <= '0;
         r_rb     <= 1'b0;
      end else if (w_btn_s == r_rb) begin
         r_db_cnt <= '0;
      end else if (r_db_cnt == CNT_LAST) begin
         r_rb     <= w_btn_s;
         r_db_cnt <= '0;
      end else begin
         r_db_cnt <= r_db_cnt + 1'b1;
      end
   end

   // ---- dice counters: die2 advances only when die1 wraps from 6 ----
   assign w_die1_nxt  = die_next(r_die1);
   assign w_die2_nxt  = die_next(r_die2);
   assign w_die1_wrap = (r_die1 == 3'd6);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_die1 <= 3'd1;
         r_die2 <= 3'd1;
      end else if (roll) begin
         r_die1 <= w_die1_nxt;
         if (w_die1_wrap) begin
            r_die2 <= w_die2_nxt;
         end
      end
   end

   // ---- result capture on the falling edge of roll ----
   // The dice hold on the same edge (roll is 0), so the total seen here is
   // exactly the value left after the last advance.
   assign w_roll_fall = r_roll_d & ~roll;
   assign w_sum_nxt   = dice_total(r_die1, r_die2);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_roll_d    <= 1'b0;
         r_sum       <= 4'd0;
         r_sum_valid <= 1'b0;
      end else begin
         r_roll_d    <= roll;
         r_sum_valid <= w_roll_fall;
         if (w_roll_fall) begin
            r_sum <= w_sum_nxt;
         end
      end
   end

   assign rb        = r_rb;
   assign die1      = r_die1;
   assign die2      = r_die2;
   assign sum       = r_sum;
   assign sum_valid = r_sum_valid;

endmodule

// File: tb/tb_dice_roller.sv
module tb_dice_roller;
   localparam int DB = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       btn;
   logic       roll;
   logic       rb;
   logic [2:0] die1;
   logic [2:0] die2;
   logic [3:0] sum;
   logic       sum_valid;

   int n_checks = 0;
   int n_fail   = 0;
   int n_pulse  = 0;
   int k_adv    = 0;
   logic [3:0] exp_q[$];

   dice_roller #(.DEBOUNCE_CYCLES(DB)) dut (
      .clk(clk), .reset(reset), .btn(btn), .roll(roll), .rb(rb),
      .die1(die1), .die2(die2), .sum(sum), .sum_valid(sum_valid)
   );

   always #5 clk = ~clk;

   // count sum_valid pulses, sampled shortly after each rising edge
   always @(posedge clk) begin
      #1;
      if (sum_valid === 1'b1) n_pulse++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   // dice model: k advances from (1,1)
   function automatic logic [2:0] m_d1(input int k);
      return 3'((k % 6) + 1);
   endfunction
   function automatic logic [2:0] m_d2(input int k);
      return 3'(((k / 6) % 6) + 1);
   endfunction
   function automatic logic [3:0] m_sum(input int k);
      return 4'(((k % 6) + 1) + (((k / 6) % 6) + 1));
   endfunction

   task automatic apply_reset();
      @(negedge clk);
      roll = 1'b0; btn = 1'b0;
      #2 reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      k_adv = 0;
      exp_q.delete();
   endtask

   task automatic drive_roll(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         roll = 1'b1;
         k_adv++;
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      btn = 1'b1;
      drive_roll(3);
      @(negedge clk);
      roll = 1'b0;
      repeat (8) @(negedge clk);
      n_checks++; if (sum !== 4'd5) begin n_fail++; $display("FAIL pre_reset_sum: got %0d expected 5", sum); end
      n_checks++; if (rb !== 1'b1) begin n_fail++; $display("FAIL pre_reset_rb: got %b expected 1", rb); end
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      n_checks++; if (rb !== 1'b0) begin n_fail++; $display("FAIL reset_rb: got %b expected 0", rb); end
      n_checks++; if (die1 !== 3'd1 || die2 !== 3'd1) begin n_fail++; $display("FAIL reset_dice: got %0d,%0d expected 1,1", die1, die2); end
      n_checks++; if (sum !== 4'd0) begin n_fail++; $display("FAIL reset_sum: got %0d expected 0", sum); end
      n_checks++; if (sum_valid !== 1'b0) begin n_fail++; $display("FAIL reset_sum_valid: got %b expected 0", sum_valid); end
      @(negedge clk);
      reset = 1'b0; btn = 1'b0; roll = 1'b0;
      k_adv = 0;
      exp_q.delete();
   endtask

   task automatic test_debounce();
      apply_reset();
      // 3-cycle glitch must be filtered
      @(negedge clk);
      btn = 1'b1;
      repeat (3) @(negedge clk);
      btn = 1'b0;
      for (int j = 1; j <= 10; j++) begin
         @(negedge clk);
         n_checks++; if (rb !== 1'b0) begin n_fail++; $display("FAIL glitch_rb[%0d]: got %b expected 0", j, rb); end
      end
      // held press: rb rises on the 6th sampling edge
      @(negedge clk);
      btn = 1'b1;
      for (int j = 1; j <= 8; j++) begin
         @(negedge clk);
         n_checks++; if (rb !== (j >= 6)) begin n_fail++; $display("FAIL press_rb[%0d]: got %b expected %b", j, rb, (j >= 6)); end
      end
      // release: rb falls 6 edges later
      @(negedge clk);
      btn = 1'b0;
      for (int j = 1; j <= 8; j++) begin
         @(negedge clk);
         n_checks++; if (rb !== (j < 6)) begin n_fail++; $display("FAIL release_rb[%0d]: got %b expected %b", j, rb, (j < 6)); end
      end
   endtask

   task automatic test_single_roll();
      int p0, lat;
      bit got;
      logic [3:0] e;
      apply_reset();
      p0 = n_pulse;
      drive_roll(1);
      @(negedge clk);
      n_checks++; if (die1 !== 3'd2 || die2 !== 3'd1) begin n_fail++; $display("FAIL single_dice: got %0d,%0d expected 2,1", die1, die2); end
      roll = 1'b0;
      exp_q.push_back(4'd3);
      got = 0; lat = 0;
      for (int c = 0; c < 4 && !got; c++) begin
         @(negedge clk);
         if (sum_valid === 1'b1) begin got = 1; lat = c; end
      end
      n_checks++; if (!got) begin n_fail++; $display("FAIL single_timeout: got no sum_valid expected pulse"); end
      n_checks++; if (lat != 0) begin n_fail++; $display("FAIL single_latency: got %0d expected 0", lat); end
      e = exp_q.pop_front();
      n_checks++; if (sum !== e) begin n_fail++; $display("FAIL single_sum: got %0d expected %0d", sum, e); end
      @(negedge clk);
      n_checks++; if (sum_valid !== 1'b0) begin n_fail++; $display("FAIL single_pulse_width: got %b expected 0", sum_valid); end
      n_checks++; if (n_pulse - p0 != 1) begin n_fail++; $display("FAIL single_pulse_count: got %0d expected 1", n_pulse - p0); end
   endtask

   task automatic test_long_rolls();
      int lens[3]        = '{6, 35, 36};
      logic [2:0] e1[3]  = '{3'd1, 3'd6, 3'd1};
      logic [2:0] e2[3]  = '{3'd2, 3'd6, 3'd1};
      int p0;
      bit got;
      logic [3:0] e;
      for (int t = 0; t < 3; t++) begin
         apply_reset();
         p0 = n_pulse;
         drive_roll(lens[t]);
         @(negedge clk);
         n_checks++; if (die1 !== e1[t] || die2 !== e2[t]) begin n_fail++; $display("FAIL long%0d_dice: got %0d,%0d expected %0d,%0d", lens[t], die1, die2, e1[t], e2[t]); end
         roll = 1'b0;
         exp_q.push_back(m_sum(k_adv));
         got = 0;
         for (int c = 0; c < 4 && !got; c++) begin
            @(negedge clk);
            if (sum_valid === 1'b1) got = 1;
         end
         e = exp_q.pop_front();
         n_checks++; if (!got) begin n_fail++; $display("FAIL long%0d_timeout: got no sum_valid expected pulse", lens[t]); end
         n_checks++; if (sum !== e) begin n_fail++; $display("FAIL long%0d_sum: got %0d expected %0d", lens[t], sum, e); end
         repeat (3) @(negedge clk);
         n_checks++; if (n_pulse - p0 != 1) begin n_fail++; $display("FAIL long%0d_pulse_count: got %0d expected 1", lens[t], n_pulse - p0); end
      end
   endtask

   task automatic test_back_to_back();
      int p0;
      logic [3:0] e;
      apply_reset();
      p0 = n_pulse;
      drive_roll(2);
      @(negedge clk);
      roll = 1'b0;
      exp_q.push_back(m_sum(k_adv));
      @(negedge clk);
      n_checks++; if (sum_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid1: got %b expected 1", sum_valid); end
      e = exp_q.pop_front();
      n_checks++; if (sum !== e) begin n_fail++; $display("FAIL b2b_sum1: got %0d expected %0d", sum, e); end
      roll = 1'b1; k_adv++;
      @(negedge clk);
      roll = 1'b1; k_adv++;
      @(negedge clk);
      n_checks++; if (sum_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_gap: got %b expected 0", sum_valid); end
      roll = 1'b0;
      exp_q.push_back(m_sum(k_adv));
      @(negedge clk);
      n_checks++; if (sum_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid2: got %b expected 1", sum_valid); end
      e = exp_q.pop_front();
      n_checks++; if (sum !== e) begin n_fail++; $display("FAIL b2b_sum2: got %0d expected %0d", sum, e); end
      repeat (2) @(negedge clk);
      n_checks++; if (n_pulse - p0 != 2) begin n_fail++; $display("FAIL b2b_pulse_count: got %0d expected 2", n_pulse - p0); end
   endtask

   task automatic test_reset_mid_roll();
      int p0;
      bit got;
      logic [3:0] e;
      apply_reset();
      drive_roll(4);
      @(negedge clk);
      n_checks++; if (die1 !== m_d1(k_adv) || die2 !== m_d2(k_adv)) begin n_fail++; $display("FAIL midroll_pre: got %0d,%0d expected %0d,%0d", die1, die2, m_d1(k_adv), m_d2(k_adv)); end
      p0 = n_pulse;
      #2 reset = 1'b1;
      #1;
      n_checks++; if (die1 !== 3'd1 || die2 !== 3'd1) begin n_fail++; $display("FAIL midroll_dice: got %0d,%0d expected 1,1", die1, die2); end
      @(negedge clk);
      reset = 1'b0;
      k_adv = 1;              // roll still high: next edge advances from 1,1
      @(negedge clk);
      k_adv++;
      @(negedge clk);
      n_checks++; if (sum !== 4'd0) begin n_fail++; $display("FAIL midroll_sum_hold: got %0d expected 0", sum); end
      n_checks++; if (n_pulse != p0) begin n_fail++; $display("FAIL midroll_no_pulse: got %0d expected 0", n_pulse - p0); end
      n_checks++; if (die1 !== m_d1(k_adv) || die2 !== m_d2(k_adv)) begin n_fail++; $display("FAIL midroll_resume: got %0d,%0d expected %0d,%0d", die1, die2, m_d1(k_adv), m_d2(k_adv)); end
      roll = 1'b0;
      exp_q.push_back(m_sum(k_adv));
      got = 0;
      for (int c = 0; c < 4 && !got; c++) begin
         @(negedge clk);
         if (sum_valid === 1'b1) got = 1;
      end
      e = exp_q.pop_front();
      n_checks++; if (!got) begin n_fail++; $display("FAIL midroll_timeout: got no sum_valid expected pulse"); end
      n_checks++; if (sum !== e) begin n_fail++; $display("FAIL midroll_sum: got %0d expected %0d", sum, e); end
   endtask

   task automatic test_idle_btn();
      int p0;
      int seg_len[6]  = '{10, 10, 2, 8, 10, 10};
      logic seg_lv[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic seg_rb[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      apply_reset();
      drive_roll(7);
      @(negedge clk);
      roll = 1'b0;
      repeat (3) @(negedge clk);
      p0 = n_pulse;
      for (int s = 0; s < 6; s++) begin
         btn = seg_lv[s];
         repeat (seg_len[s]) @(negedge clk);
         n_checks++; if (rb !== seg_rb[s]) begin n_fail++; $display("FAIL idle_rb[%0d]: got %b expected %b", s, rb, seg_rb[s]); end
         n_checks++; if (die1 !== m_d1(k_adv) || die2 !== m_d2(k_adv)) begin n_fail++; $display("FAIL idle_dice[%0d]: got %0d,%0d expected %0d,%0d", s, die1, die2, m_d1(k_adv), m_d2(k_adv)); end
      end
      n_checks++; if (n_pulse != p0) begin n_fail++; $display("FAIL idle_no_pulse: got %0d expected 0", n_pulse - p0); end
   endtask

   initial begin
      reset = 1'b1;
      btn   = 1'b0;
      roll  = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      test_reset();
      test_debounce();
      test_single_roll();
      test_long_rolls();
      test_back_to_back();
      test_reset_mid_roll();
      test_idle_btn();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dice_roller.md
# dice_roller

Dice datapath and button front end for the dice game controller. It conditions the raw roll pushbutton into the clean `rb` level that the controller samples. While the controller holds `roll` high, it advances two cascaded 1..6 counters. When `roll` falls, it registers their total onto `sum` and pulses `sum_valid`. Its `rb` output feeds the controller's `rb` input, and its `sum` output feeds the controller's `sum` input.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: number of consecutive cycles the synchronized button must differ from `rb` before `rb` changes. Legal range is 1..255.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `btn`  in  1  raw pushbutton, asynchronous to `clk`, may bounce.
- `roll`  in  1  roll command from the controller; dice advance while it is high.
- `rb`  out  1  debounced button level, sent to the controller.
- `die1`  out  3  first die value, 1..6.
- `die2`  out  3  second die value, 1..6.
- `sum`  out  4  registered `die1`+`die2`, 2..12. It reads 0 only after reset.
- `sum_valid`  out  1  one-cycle pulse when `sum` is updated.

## Operation
Reset values, applied immediately while `reset` is high and without waiting for a clock edge:
- sync flops = 0, debounce counter = 0, `rb` = 0
- `die1` = 1, `die2` = 1
- `roll_d` = 0
- `sum` = 0, `sum_valid` = 0

Synchronizer:
- `btn` passes through two flops, giving `btn_s`.

Debounce:
- If `btn_s` == `rb`: counter <= 0.
- Otherwise, if counter == `DEBOUNCE_CYCLES`-1: `rb` <= `btn_s` and counter <= 0.
- Otherwise: counter++.
- Any cycle where `btn_s` matches `rb` restarts the count. Glitches shorter than `DEBOUNCE_CYCLES` cycles never reach `rb`.

Dice counters, evaluated each edge:
- `roll`=1:
  - `die1` <= (`die1`==6) ? 1 : `die1`+1.
  - If `die1`==6, then also `die2` <= (`die2`==6) ? 1 : `die2`+1.
- `roll`=0: both dice hold.
- Any illegal value (0 or 7) advances to 1. This is a defensive rule only; legal operation never produces such a value.
- The pair cycles through all 36 combinations with period 36.

Result capture:
- `roll_d` <= `roll` every edge.
- On an edge where `roll`==0 and `roll_d`==1:
  - `sum` <= `die1`+`die2`, computed 4 bits wide with no overflow (maximum 12).
  - `sum_valid` <= 1.
- On all other edges, `sum_valid` <= 0 and `sum` holds.
- `sum` keeps its last value through later rolls until the next falling edge of `roll`.

## Timing
- `rb` latency: a clean `btn` transition reaches `rb` 2 + `DEBOUNCE_CYCLES` edges after the first edge that samples it.
- Dice latency: the dice change on the same edge that samples `roll`=1, so there are N advances for N cycles of `roll` high.
- `sum`/`sum_valid` latency: both update on the first edge sampling `roll`=0 after `roll` was high.
  - `sum` uses the dice values left after the last advance.
  - The dice are frozen on that edge, so there is no race.
- `roll` high for exactly one cycle gives one advance, followed by `sum_valid` on the next edge.
- Back-to-back operation: `roll` high, one cycle low, then high again is legal. Each falling edge produces its own pulse.
- Reset mid-roll: `roll_d` is cleared, so no `sum_valid` is produced by the reset itself.
  - If `roll` is still high after reset deasserts, counting resumes from 1,1.
  - The next falling edge of `roll` produces a valid result.
- `roll` held low: the dice stay frozen and `sum_valid` never asserts. `btn` activity does not affect the dice.

## Test plan
- Async reset: assert `reset` between clock edges → `rb`=0, `die1`=`die2`=1, `sum`=0, `sum_valid`=0 before the next edge.
- Debounce with `DEBOUNCE_CYCLES`=4:
  - 3-cycle high glitch on `btn` → `rb` stays 0.
  - `btn` held high → `rb` rises on the 6th edge after the first sampling edge.
  - Release `btn` → `rb` falls 6 edges later.
- Single-cycle `roll` after reset → `die1`=2, `die2`=1. Next edge: `sum`=3 and `sum_valid`=1 for exactly one cycle.
- Long rolls from reset:
  - 6 cycles → (1,2), `sum`=3.
  - 35 cycles → (6,6), `sum`=12.
  - 36 cycles → (1,1), `sum`=2.
  - In each case exactly one `sum_valid` pulse.
- Reset asserted while `roll`=1 after 4 advances → dice return to 1,1, no `sum_valid`, and `sum` stays 0 until a later roll completes.
- `roll` held low for 50 cycles while `btn` toggles → dice stay constant and `sum_valid` stays 0. `rb` tracks the debounced `btn`.
